// File: rtl/tdm_chan_mux_pkg.sv
// Shared types for the TDM channel multiplexer: mode/state encodings and
// the channel-index width helper.
package tdm_chan_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SWEEP  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Width of a channel index for n channels; never narrower than one bit.
  function automatic int chan_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tdm_pipe_reg.sv
// One elastic valid/ready register slice; loads whenever it is empty or its
// current contents are being consumed.
module tdm_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Slice register: hold while stalled, otherwise take whatever is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {DW{1'b0}};
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
      end
    end
  end

endmodule

// File: rtl/tdm_chan_mux.sv
// N-channel selector with direct and sweep modes behind an elastic output
// register. Define TDM_CHAN_MUX_PIPE2_EN to add a second output stage.
module tdm_chan_mux
  import tdm_chan_mux_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int N    = 4,
  localparam int SELW = chan_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] out_chan,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  localparam int DW = W + SELW + 1;

  state_e          state_q, state_d;
  logic [N*W-1:0]  snap_q, snap_d;
  logic [SELW-1:0] idx_q, idx_d;
  logic            busy_q, busy_d;

  logic            load_ok;
  logic            s1_in_valid;
  logic [W-1:0]    ld_data;
  logic [SELW-1:0] ld_chan;
  logic            ld_last;
  logic [W-1:0]    direct_data;
  logic [W-1:0]    sweep_data;
  logic            idx_at_end;
  logic [DW-1:0]   out_data;

  assign busy       = busy_q;
  assign idx_at_end = (idx_q == SELW'(N - 1));
  assign sweep_data = snap_q[int'(idx_q)*W +: W];

  // Direct select; indices past the last channel read as zero.
  always_comb begin
    direct_data = {W{1'b0}};
    if (int'(sel) < N) begin
      direct_data = din[int'(sel)*W +: W];
    end else begin
      direct_data = {W{1'b0}};
    end
  end

  // Control FSM: decides what is offered to stage 1 and advances the sweep.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    in_ready    = 1'b0;
    s1_in_valid = 1'b0;
    ld_data     = {W{1'b0}};
    ld_chan     = {SELW{1'b0}};
    ld_last     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = load_ok;
        if (in_valid && load_ok) begin
          s1_in_valid = 1'b1;
          if (mode_e'(mode) == MODE_SWEEP) begin
            // Channel 0 goes out directly from live din, matching the snapshot.
            ld_data = din[W-1:0];
            ld_chan = {SELW{1'b0}};
            ld_last = 1'b0;
            snap_d  = din;
            idx_d   = SELW'(1);
            busy_d  = 1'b1;
            state_d = ST_SWEEP;
          end else begin
            ld_data = direct_data;
            ld_chan = sel;
            ld_last = 1'b1;
          end
        end else begin
          s1_in_valid = 1'b0;
        end
      end
      ST_SWEEP: begin
        s1_in_valid = 1'b1;
        ld_data     = sweep_data;
        ld_chan     = idx_q;
        ld_last     = idx_at_end;
        if (load_ok) begin
          if (idx_at_end) begin
            idx_d   = {SELW{1'b0}};
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + SELW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        idx_d   = {SELW{1'b0}};
      end
    endcase
  end

  // FSM, snapshot and sweep index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= {(N*W){1'b0}};
      idx_q   <= {SELW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef TDM_CHAN_MUX_PIPE2_EN
  logic          s1_out_valid;
  logic          s2_in_ready;
  logic [DW-1:0] s1_out_data;

  tdm_pipe_reg #(.DW(DW)) u_stage1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_in_valid),
    .in_ready_o  (load_ok),
    .in_data_i   ({ld_data, ld_chan, ld_last}),
    .out_valid_o (s1_out_valid),
    .out_ready_i (s2_in_ready),
    .out_data_o  (s1_out_data)
  );

  tdm_pipe_reg #(.DW(DW)) u_stage2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_out_valid),
    .in_ready_o  (s2_in_ready),
    .in_data_i   (s1_out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );
`else
  tdm_pipe_reg #(.DW(DW)) u_stage1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_in_valid),
    .in_ready_o  (load_ok),
    .in_data_i   ({ld_data, ld_chan, ld_last}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );
`endif

  assign {dout, out_chan, out_last} = out_data;

endmodule

// File: tb/tb_tdm_chan_mux.sv
// Directed self-checking bench for tdm_chan_mux (N=4 and N=3 instances);
// latency expectations follow TDM_CHAN_MUX_PIPE2_EN.
module tb_tdm_chan_mux;

`ifdef TDM_CHAN_MUX_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [63:0] DIN4 = 64'h4000_2000_C000_7FFF;
  localparam logic [47:0] DIN3 = 48'h2000_C000_7FFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] din = 64'h0;
  logic [1:0]  sel = 2'd0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dout;
  logic [1:0]  out_chan;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  logic [47:0] din3 = 48'h0;
  logic [1:0]  sel3 = 2'd0;
  logic        mode3 = 1'b0;
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [15:0] dout3;
  logic [1:0]  out_chan3;
  logic        out_last3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic        busy3;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_ch [4] = '{16'h7FFF, 16'hC000, 16'h2000, 16'h4000};
  logic [19:0] act_v, exp_v;

  always #5 clk = ~clk;

  tdm_chan_mux #(.W(16), .N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .out_chan(out_chan),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  tdm_chan_mux #(.W(16), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .mode(mode3),
    .in_valid(in_valid3), .in_ready(in_ready3), .dout(dout3), .out_chan(out_chan3),
    .out_last(out_last3), .out_valid(out_valid3), .out_ready(out_ready3), .busy(busy3)
  );

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    act_v = {out_valid, dout, out_chan, out_last};
    checks++;
    if (act_v !== 20'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_n4: got %h busy=%b expected 00000 busy=0", act_v, busy);
    end
    act_v = {out_valid3, dout3, out_chan3, out_last3};
    checks++;
    if (act_v !== 20'h0 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_n3: got %h busy=%b expected 00000 busy=0", act_v, busy3);
    end
    din = DIN4;
    din3 = DIN3;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_direct();
    mode = 1'b0; sel = 2'd2; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL direct_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    act_v = {out_valid, dout, out_chan, out_last};
    exp_v = {1'b1, 16'h2000, 2'd2, 1'b1};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL direct_sel2: got %h expected %h", act_v, exp_v);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL direct_one_cycle: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    mode = 1'b0; sel = 2'd0; in_valid = 1'b1;
    for (int c = 0; c < 4 + LAT - 1; c++) begin
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", c, in_ready);
        end
      end
      @(posedge clk); #1;
      if (c + 1 < 4) sel = 2'(c + 1);
      else in_valid = 1'b0;
      if (c >= LAT - 1) begin
        e = c - LAT + 1;
        act_v = {out_valid, dout, out_chan, out_last};
        exp_v = {1'b1, exp_ch[e], 2'(e), 1'b1};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL b2b_elem%0d: got %h expected %h", e, act_v, exp_v);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_sweep();
    int e;
    mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 1'b0;
    for (int c = 0; c < 4 + LAT - 1; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 4) begin
        checks++;
        if (busy !== (c < 3)) begin
          failures++;
          $display("FAIL sweep_busy: cycle %0d got %b expected %b", c, busy, (c < 3));
        end
      end
      if (c < 3) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL sweep_in_ready: cycle %0d got %b expected 0", c, in_ready);
        end
      end
      if (c >= LAT - 1) begin
        e = c - LAT + 1;
        act_v = {out_valid, dout, out_chan, out_last};
        exp_v = {1'b1, exp_ch[e], 2'(e), (e == 3)};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL sweep_elem%0d: got %h expected %h", e, act_v, exp_v);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 1'b0;
    n = 0;
    while (!(out_valid === 1'b1 && out_chan === 2'd1) && n < 8) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 8) begin
      failures++;
      $display("FAIL bp_find_ch1: timeout after %0d cycles, expected ch1", n);
    end
    out_ready = 1'b0;
    din = 64'hDEAD_BEEF_1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      act_v = {out_valid, dout, out_chan, out_last};
      exp_v = {1'b1, 16'hC000, 2'd1, 1'b0};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL bp_hold%0d: got %h expected %h", k, act_v, exp_v);
      end
    end
    out_ready = 1'b1;
    for (int e = 2; e < 4; e++) begin
      @(posedge clk); #1;
      act_v = {out_valid, dout, out_chan, out_last};
      exp_v = {1'b1, exp_ch[e], 2'(e), (e == 3)};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL bp_elem%0d: got %h expected %h", e, act_v, exp_v);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: out_valid got %b expected 0", out_valid);
    end
    din = DIN4;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 1'b0;
    n = 0;
    while (!(out_valid === 1'b1 && out_chan === 2'd2) && n < 8) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 8) begin
      failures++;
      $display("FAIL rst_find_ch2: timeout after %0d cycles, expected ch2", n);
    end
    #2 rst_n = 1'b0;
    #1;
    act_v = {out_valid, dout, out_chan, out_last};
    checks++;
    if (act_v !== 20'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got %h busy=%b expected 00000 busy=0", act_v, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_resume: out_valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    mode = 1'b0; sel = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    act_v = {out_valid, dout, out_chan, out_last};
    exp_v = {1'b1, 16'h7FFF, 2'd0, 1'b1};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL rst_then_direct: got %h expected %h", act_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_n3();
    int e;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    act_v = {out_valid3, dout3, out_chan3, out_last3};
    exp_v = {1'b1, 16'h0000, 2'd3, 1'b1};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL n3_sel_oob: got %h expected %h", act_v, exp_v);
    end
    @(posedge clk); #1;
    sel3 = 2'd0; in_valid3 = 1'b1;
    for (int c = 0; c < 3 + LAT - 1; c++) begin
      @(posedge clk); #1;
      if (c + 1 < 3) sel3 = 2'(c + 1);
      else in_valid3 = 1'b0;
      if (c >= LAT - 1) begin
        e = c - LAT + 1;
        act_v = {out_valid3, dout3, out_chan3, out_last3};
        exp_v = {1'b1, exp_ch[e], 2'(e), 1'b1};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL n3_b2b_elem%0d: got %h expected %h", e, act_v, exp_v);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid3 !== 1'b0) begin
      failures++;
      $display("FAIL n3_drain: out_valid got %b expected 0", out_valid3);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_back_to_back();
    test_sweep();
    test_backpressure();
    test_reset_mid_sweep();
    test_n3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_chan_mux.md
Name: tdm_chan_mux

Overview:
- Parametrised N-channel, W-bit selector with a registered output and a valid/ready handshake.
- Two modes:
  - Direct mode: forwards one caller-selected channel per transfer.
  - Sweep mode: snapshots all N channels and emits them in order 0..N-1, so the basis-expansion terms can be time-multiplexed onto a single downstream multiplier/adder in the filter datapath.

Parameters:
- W, 16, data width per channel (two's-complement Q-format, passed through untouched).
- N, 4, channel count, N >= 2; need not be a power of two.
- SELW, $clog2(N), select/channel-index width (localparam, derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  N*W  packed channels; channel k occupies din[k*W +: W].
- sel  in  SELW  channel index in direct mode.
- mode  in  1  0 = direct, 1 = sweep; sampled only when a transfer or sweep starts.
- in_valid  in  1  direct-mode request / sweep-mode start qualifier.
- in_ready  out  1  block can accept a request this cycle.
- dout  out  W  selected channel data.
- out_chan  out  SELW  channel index of dout.
- out_last  out  1  dout is the final element of a sweep (always 1 in direct mode).
- out_valid  out  1  dout/out_chan/out_last valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  sweep in progress.

Behaviour:
- Reset: dout=0, out_chan=0, out_last=0, out_valid=0, busy=0, FSM=IDLE, snapshot register=0. Reset is asynchronous and effective at any time, including mid-sweep; no partial sweep resumes after reset.
- A handshake completes when valid && ready on the rising edge.
- Output register update:
  - The output register loads when it is empty or being consumed, i.e. load_ok = !out_valid || out_ready.
  - Data is held stable while out_valid && !out_ready.
- FSM state IDLE:
  - in_ready = load_ok.
  - On in_valid && in_ready with mode=0: dout <= din[sel], out_chan <= sel, out_last <= 1, out_valid <= 1. Latency is 1 cycle. The FSM stays in IDLE.
  - If sel >= N (non-power-of-two N): dout <= 0, out_chan <= sel, and the transfer still completes.
  - On in_valid && in_ready with mode=1: snapshot <= din. The channel 0 output loads the same edge from live din[0] (identical to snapshot[0]). out_chan <= 0, out_last <= (N==1 ? 1 : 0), busy <= 1, idx <= 1. Next state is SWEEP.
- FSM state SWEEP:
  - in_ready = 0, and in_valid is ignored.
  - Each cycle with load_ok, load snapshot[idx]: out_chan <= idx, out_last <= (idx == N-1), then idx <= idx+1.
  - After loading idx == N-1, busy <= 0 and the next state is IDLE.
  - Back-pressure stalls idx without dropping or duplicating elements.
- Throughput: one element per cycle when out_ready is held high. A sweep of N=4 occupies exactly 4 consecutive out_valid cycles.
- Back-to-back operation: in the cycle after the last sweep element is loaded, IDLE may accept a new request. There are no dead cycles in direct mode.
- Changes to din/sel/mode during a sweep have no effect on the sweep in progress.

Optional Feature:
- Macro: TDM_CHAN_MUX_PIPE2_EN.
- When defined:
  - A second output register stage is added for timing; it is elastic and every stage uses the same load_ok rule.
  - Latency from acceptance to out_valid is 2 cycles.
  - Throughput stays 1/cycle and ordering is unchanged.
  - in_ready reflects stage-1 availability.
- When undefined: single stage, latency 1.
- Reset clears both stages.

Decomposition:
- Shared package: mode encodings (MODE_DIRECT=0, MODE_SWEEP=1), FSM state encoding (IDLE, SWEEP), and the function computing the channel field width.
- One sub-module is natural: tdm_pipe_reg, one elastic valid/ready register slice carrying {dout, out_chan, out_last}. It is instantiated once normally and twice under TDM_CHAN_MUX_PIPE2_EN.
- The N-way select itself is a parametrised indexed part-select inside the top module.

Test Plan:
- Direct mode: N=4, W=16, din={16'h4000,16'h2000,16'hC000,16'h7FFF} (ch3..ch0), sel=2, in_valid pulse with out_ready=1 -> one cycle later dout=16'h2000, out_chan=2, out_last=1, out_valid for 1 cycle.
- Sweep mode: mode=1, in_valid pulse, out_ready=1 -> 4 consecutive out_valid cycles with dout 7FFF, C000, 2000, 4000 and out_chan 0..3; out_last only on out_chan=3; busy high through the last load; in_ready=0 throughout.
- Back-pressure mid-sweep: out_ready=0 for 3 cycles while out_chan=1 -> dout holds C000 for those cycles, then ch2 and ch3 follow; no loss or duplication. Changing din during the sweep does not alter the outputs.
- Reset mid-sweep: assert rst_n=0 asynchronously while out_chan=2 -> out_valid=0, busy=0, dout=0 immediately. After release, a direct request with sel=0 returns 7FFF.
- N=3 with sel=3 in direct mode -> dout=0, out_chan=3, transfer completes. Back-to-back direct requests with sel=0,1,2 on consecutive cycles -> 3 consecutive valid outputs.
- Build with TDM_CHAN_MUX_PIPE2_EN and repeat the sweep test -> first out_valid appears 2 cycles after acceptance; sequence and out_last placement are identical.
